// File: rtl/cpu_control_fsm.sv
// Purpose : multi-cycle CPU control unit sequencing FETCH/DECODE/EXECUTE/MEM/WRITEBACK,
//           with a bounded wait on mem_ready that ends in a sticky FAULT state.
// Latency : R/I/NOP 3 cycles, STOR 4, LOAD 5, each plus memory wait cycles.
// Backpressure: mem_ready stalls FETCH and MEM; WAIT_LIMIT stalled cycles without it -> FAULT.
// Ports   : clk, reset (async, active-high); instr[15:0] and mem_ready in;
//           imm_select, alu_op[3:0], rf_we, wb_sel, addr_sel, mem_re, mem_we, ir_load,
//           pc_en, halted, error and state_dbg[2:0] out.
module cpu_control_fsm #(
  parameter int unsigned WAIT_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        mem_ready,
  output logic        imm_select,
  output logic [3:0]  alu_op,
  output logic        rf_we,
  output logic        wb_sel,
  output logic        addr_sel,
  output logic        mem_re,
  output logic        mem_we,
  output logic        ir_load,
  output logic        pc_en,
  output logic        halted,
  output logic        error,
  output logic [2:0]  state_dbg
);

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_MEM       = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_HALT      = 3'd5;
  localparam logic [2:0] S_FAULT     = 3'd6;

  // The stall that would bring the count up to WAIT_LIMIT is the faulting one.
  localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

  logic [2:0] state, state_nxt;
  logic [3:0] op_q, ext_q;
  logic [7:0] wait_cnt;

  logic cls_r, cls_i, cls_ld, cls_st, cls_nop, cls_halt;
  logic waiting, timeout;

  assign cls_r    = (op_q == 4'h0);
  assign cls_i    = (op_q >= 4'h1) && (op_q <= 4'h9);
  assign cls_ld   = (op_q == 4'hA);
  assign cls_st   = (op_q == 4'hB);
  assign cls_nop  = (op_q >= 4'hC) && (op_q <= 4'hE);
  assign cls_halt = (op_q == 4'hF);

  assign waiting = (state == S_FETCH) || (state == S_MEM);
  assign timeout = waiting && !mem_ready && (wait_cnt == LIMIT_M1);

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: begin
        if (mem_ready)    state_nxt = S_DECODE;
        else if (timeout) state_nxt = S_FAULT;
      end
      S_DECODE: state_nxt = S_EXECUTE;
      S_EXECUTE: begin
        if (cls_halt)                state_nxt = S_HALT;
        else if (cls_ld || cls_st)   state_nxt = S_MEM;
        else                         state_nxt = S_FETCH;
      end
      S_MEM: begin
        if (mem_ready)    state_nxt = cls_ld ? S_WRITEBACK : S_FETCH;
        else if (timeout) state_nxt = S_FAULT;
      end
      S_WRITEBACK: state_nxt = S_FETCH;
      S_HALT:      state_nxt = S_HALT;
      S_FAULT:     state_nxt = S_FAULT;
      default:     state_nxt = S_FAULT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      op_q     <= 4'h0;
      ext_q    <= 4'h0;
      wait_cnt <= 8'h00;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) begin
        op_q  <= instr[15:12];
        ext_q <= instr[7:4];
      end
      // Clear on entry to a waiting state, otherwise count stalled cycles.
      if ((state_nxt != state) && ((state_nxt == S_FETCH) || (state_nxt == S_MEM)))
        wait_cnt <= 8'h00;
      else if (waiting && !mem_ready)
        wait_cnt <= wait_cnt + 8'h01;
    end
  end

  always_comb begin
    imm_select = 1'b0;
    alu_op     = 4'h0;
    rf_we      = 1'b0;
    wb_sel     = 1'b0;
    addr_sel   = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    ir_load    = 1'b0;
    pc_en      = 1'b0;
    halted     = 1'b0;
    error      = 1'b0;
    state_dbg  = state;
    case (state)
      S_FETCH: begin
        mem_re  = 1'b1;
        ir_load = mem_ready;
      end
      S_EXECUTE: begin
        if (cls_r) begin
          alu_op = ext_q;
          rf_we  = 1'b1;
          pc_en  = 1'b1;
        end else if (cls_i) begin
          alu_op     = op_q;
          imm_select = 1'b1;
          rf_we      = 1'b1;
          pc_en      = 1'b1;
        end else if (cls_nop) begin
          pc_en = 1'b1;
        end
      end
      S_MEM: begin
        addr_sel   = 1'b1;
        imm_select = 1'b1;
        mem_re     = cls_ld;
        mem_we     = cls_st;
        pc_en      = cls_st && mem_ready;
      end
      S_WRITEBACK: begin
        rf_we  = 1'b1;
        wb_sel = 1'b1;
        pc_en  = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: begin
        halted = 1'b1;
        error  = 1'b1;
      end
      default: ;
    endcase
    // Reset silences every strobe immediately, even mid-transaction.
    if (reset) begin
      imm_select = 1'b0;
      alu_op     = 4'h0;
      rf_we      = 1'b0;
      wb_sel     = 1'b0;
      addr_sel   = 1'b0;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      ir_load    = 1'b0;
      pc_en      = 1'b0;
      halted     = 1'b0;
      error      = 1'b0;
      state_dbg  = S_FETCH;
    end
  end

endmodule
